// File: rtl/uart_link_scheduler.sv
// Board-to-board UART link scheduler: vsync-paced frame snapshots written round-robin to both
// TX FIFOs, plus per-link RX draining, frame validation and liveness timeout.
module uart_link_scheduler #(
   parameter int FRAMES_PER_TX  = 4,
   parameter int TIMEOUT_FRAMES = 60,
   parameter int DW             = 32
) (
   input  logic          pclk,
   input  logic          rst,
   input  logic          vsync,
   input  logic [DW-1:0] tx_data_in,
   input  logic          tx_full_1,
   input  logic          tx_full_2,
   output logic          wr_uart_1,
   output logic          wr_uart_2,
   output logic [DW-1:0] tx_word,
   input  logic          rx_empty_1,
   input  logic          rx_empty_2,
   input  logic [DW-1:0] rx_word_1,
   input  logic [DW-1:0] rx_word_2,
   output logic          rd_uart_1,
   output logic          rd_uart_2,
   output logic [DW-1:0] ext_data_1,
   output logic [DW-1:0] ext_data_2,
   output logic          link_up_1,
   output logic          link_up_2,
   output logic [7:0]    tx_drop_cnt
);

   localparam int FCW = (FRAMES_PER_TX > 1) ? $clog2(FRAMES_PER_TX) : 1;
   localparam int TCW = $clog2(TIMEOUT_FRAMES + 1);

   typedef enum logic [1:0] {IDLE, WR1, WR2, GAP} tx_state_t;
   typedef enum logic {RX_IDLE, RX_POP} rx_state_t;

   function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [1:0] b);
      logic [8:0] s;
      s = {1'b0, a} + {7'b0, b};
      return s[8] ? 8'hFF : s[7:0];
   endfunction

   logic           vsync_q;
   logic           tick;
   logic [FCW-1:0] frame_cnt;
   logic           snap_req;
   logic           snap_go;
   logic           pend_1, pend_2;
   logic           prio;
   logic           elig_1, elig_2;
   tx_state_t      tx_state, tx_next;

   assign tick    = vsync & ~vsync_q;
   assign snap_go = snap_req & (tx_state != WR1) & (tx_state != WR2);
   assign elig_1  = pend_1 & ~tx_full_1;
   assign elig_2  = pend_2 & ~tx_full_2;

   always_ff @(posedge pclk or posedge rst) begin
      if (rst) begin
         vsync_q   <= 1'b0;
         frame_cnt <= '0;
         snap_req  <= 1'b0;
      end else begin
         vsync_q <= vsync;
         if (tick) begin
            if (frame_cnt == FCW'(FRAMES_PER_TX - 1)) frame_cnt <= '0;
            else                                      frame_cnt <= frame_cnt + FCW'(1);
         end
         // A fresh request outranks clearing the one being serviced.
         if (tick && (frame_cnt == FCW'(FRAMES_PER_TX - 1))) snap_req <= 1'b1;
         else if (snap_go)                                   snap_req <= 1'b0;
      end
   end

   always_ff @(posedge pclk or posedge rst) begin
      if (rst) begin
         tx_word     <= '0;
         tx_drop_cnt <= '0;
         pend_1      <= 1'b0;
         pend_2      <= 1'b0;
         prio        <= 1'b0;
      end else begin
         if (snap_go) begin
            tx_word     <= tx_data_in;
            tx_drop_cnt <= sat_add(tx_drop_cnt, {1'b0, pend_1} + {1'b0, pend_2});
            pend_1      <= 1'b1;
            pend_2      <= 1'b1;
         end else begin
            if (tx_state == WR1) pend_1 <= 1'b0;
            if (tx_state == WR2) pend_2 <= 1'b0;
         end
         if (tx_state == WR1) prio <= 1'b1;
         if (tx_state == WR2) prio <= 1'b0;
      end
   end

   always_ff @(posedge pclk or posedge rst) begin
      if (rst) tx_state <= IDLE;
      else     tx_state <= tx_next;
   end

   always_comb begin
      tx_next   = tx_state;
      wr_uart_1 = 1'b0;
      wr_uart_2 = 1'b0;
      case (tx_state)
         IDLE: begin
            if (elig_1 & (~prio | ~elig_2))      tx_next = WR1;
            else if (elig_2 & (prio | ~elig_1))  tx_next = WR2;
         end
         WR1: begin
            wr_uart_1 = 1'b1;
            tx_next   = GAP;
         end
         WR2: begin
            wr_uart_2 = 1'b1;
            tx_next   = GAP;
         end
         default: tx_next = IDLE;
      endcase
   end

   logic [1:0]    rx_empty_v;
   logic [DW-1:0] rx_word_v [2];

   assign rx_empty_v   = {rx_empty_2, rx_empty_1};
   assign rx_word_v[0] = rx_word_1;
   assign rx_word_v[1] = rx_word_2;

   for (genvar i = 0; i < 2; i++) begin : g_rx
      rx_state_t      st, nxt;
      logic           rd;
      logic           take;
      logic           valid;
      logic           up;
      logic [DW-1:0]  ext;
      logic [TCW-1:0] to_cnt;

      assign take  = (st == RX_IDLE) & ~rx_empty_v[i];
      // Null IDs and our own echoed ID are popped but never latched.
      assign valid = take & (rx_word_v[i][7:0] != 8'h00) & (rx_word_v[i][7:0] != tx_data_in[7:0]);

      always_ff @(posedge pclk or posedge rst) begin
         if (rst) st <= RX_IDLE;
         else     st <= nxt;
      end

      always_comb begin
         nxt = st;
         rd  = 1'b0;
         case (st)
            RX_IDLE: if (~rx_empty_v[i]) nxt = RX_POP;
            default: begin
               rd  = 1'b1;
               nxt = RX_IDLE;
            end
         endcase
      end

      always_ff @(posedge pclk or posedge rst) begin
         if (rst) begin
            to_cnt <= '0;
            up     <= 1'b0;
            ext    <= '0;
         end else if (valid) begin
            ext    <= rx_word_v[i];
            up     <= 1'b1;
            to_cnt <= '0;
         end else if (tick && (to_cnt != TCW'(TIMEOUT_FRAMES))) begin
            to_cnt <= to_cnt + TCW'(1);
            if (to_cnt == TCW'(TIMEOUT_FRAMES - 1)) begin
               up  <= 1'b0;
               ext <= '0;
            end
         end
      end
   end

   assign rd_uart_1  = g_rx[0].rd;
   assign rd_uart_2  = g_rx[1].rd;
   assign ext_data_1 = g_rx[0].ext;
   assign ext_data_2 = g_rx[1].ext;
   assign link_up_1  = g_rx[0].up;
   assign link_up_2  = g_rx[1].up;

endmodule

// File: tb/tb_uart_link_scheduler.sv
// Bench for uart_link_scheduler: directed TX/RX scenarios plus randomized RX and TX phases
// compared against a transaction-level model (queues for RX FIFOs, counters for writes/drops).
module tb_uart_link_scheduler;

   logic        pclk = 1'b0;
   logic        rst = 1'b1;
   logic        vsync = 1'b0;
   logic [31:0] tx_data_in = '0;
   logic        tx_full_1 = 1'b0, tx_full_2 = 1'b0;
   logic        wr_uart_1, wr_uart_2;
   logic [31:0] tx_word;
   logic        rx_empty_1 = 1'b1, rx_empty_2 = 1'b1;
   logic [31:0] rx_word_1 = '0, rx_word_2 = '0;
   logic        rd_uart_1, rd_uart_2;
   logic [31:0] ext_data_1, ext_data_2;
   logic        link_up_1, link_up_2;
   logic [7:0]  tx_drop_cnt;

   uart_link_scheduler #(.FRAMES_PER_TX(4), .TIMEOUT_FRAMES(3), .DW(32)) dut (
      .pclk(pclk), .rst(rst), .vsync(vsync), .tx_data_in(tx_data_in),
      .tx_full_1(tx_full_1), .tx_full_2(tx_full_2),
      .wr_uart_1(wr_uart_1), .wr_uart_2(wr_uart_2), .tx_word(tx_word),
      .rx_empty_1(rx_empty_1), .rx_empty_2(rx_empty_2),
      .rx_word_1(rx_word_1), .rx_word_2(rx_word_2),
      .rd_uart_1(rd_uart_1), .rd_uart_2(rd_uart_2),
      .ext_data_1(ext_data_1), .ext_data_2(ext_data_2),
      .link_up_1(link_up_1), .link_up_2(link_up_2), .tx_drop_cnt(tx_drop_cnt)
   );

   always #5 pclk = ~pclk;

   int          n_vec = 0, n_err = 0;
   int          cyc = 0;
   int          npulse = 0;
   int          n_wr1 = 0, n_wr2 = 0, n_rd1 = 0, n_rd2 = 0;
   int          t_wr1 = 0, t_wr2 = 0;
   logic [31:0] exp_word = '0;
   logic [31:0] q1[$], q2[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   always @(posedge pclk) cyc++;

   // Strobe monitor: every write must carry the frame of the current snapshot.
   always @(negedge pclk) begin
      if (!rst) begin
         if (wr_uart_1) begin n_wr1++; t_wr1 = cyc; chk("wr1_word", tx_word, exp_word); end
         if (wr_uart_2) begin n_wr2++; t_wr2 = cyc; chk("wr2_word", tx_word, exp_word); end
         if (rd_uart_1) n_rd1++;
         if (rd_uart_2) n_rd2++;
      end
   end

   // RX FIFO models: pop on the read strobe, present the head shortly after the falling edge.
   always @(negedge pclk) begin
      if (rd_uart_1 && q1.size() > 0) void'(q1.pop_front());
      if (rd_uart_2 && q2.size() > 0) void'(q2.pop_front());
      #1;
      rx_empty_1 = (q1.size() == 0);
      rx_word_1  = (q1.size() != 0) ? q1[0] : 32'h0;
      rx_empty_2 = (q2.size() == 0);
      rx_word_2  = (q2.size() != 0) ? q2[0] : 32'h0;
   end

   task automatic pulse();
      vsync = 1'b1;
      repeat (2) @(negedge pclk);
      vsync = 1'b0;
      repeat (3) @(negedge pclk);
      npulse++;
   endtask

   task automatic to_snap();
      while (npulse % 4 != 3) pulse();
   endtask

   // Snapshot pulse; the full pattern for the new frame period is applied right after the snapshot.
   task automatic snap_pulse(input logic [31:0] d, input logic f1, input logic f2);
      tx_data_in = d;
      vsync = 1'b1;
      repeat (2) @(negedge pclk);
      exp_word  = d;
      tx_full_1 = f1;
      tx_full_2 = f2;
      vsync = 1'b0;
      repeat (3) @(negedge pclk);
      npulse++;
   endtask

   initial begin
      int          c1, c2, r1, r2;
      int          exp_drop;
      logic [31:0] d, w;
      logic [31:0] m_ext1, m_ext2;
      logic        m_up1, m_up2, f1, f2, pf1, pf2, done;

      repeat (3) @(negedge pclk);
      rst = 1'b0;
      @(negedge pclk);
      chk("rst_tx_word", tx_word, 0);
      chk("rst_wr1", {31'b0, wr_uart_1}, 0);
      chk("rst_wr2", {31'b0, wr_uart_2}, 0);
      chk("rst_rd1", {31'b0, rd_uart_1}, 0);
      chk("rst_rd2", {31'b0, rd_uart_2}, 0);
      chk("rst_ext1", ext_data_1, 0);
      chk("rst_ext2", ext_data_2, 0);
      chk("rst_up1", {31'b0, link_up_1}, 0);
      chk("rst_up2", {31'b0, link_up_2}, 0);
      chk("rst_drop", {24'b0, tx_drop_cnt}, 0);

      // First snapshot on the 4th vsync rise, strobe timing cycle by cycle.
      tx_data_in = 32'h0012_3405;
      repeat (3) pulse();
      vsync = 1'b1;
      @(negedge pclk);
      chk("t1_word_before", tx_word, 0);
      @(negedge pclk);
      chk("t1_word_snap", tx_word, 32'h0012_3405);
      chk("t1_wr1_early", {31'b0, wr_uart_1}, 0);
      exp_word = 32'h0012_3405;
      vsync = 1'b0;
      @(negedge pclk);
      chk("t1_wr1_on", {31'b0, wr_uart_1}, 1);
      chk("t1_wr2_off", {31'b0, wr_uart_2}, 0);
      @(negedge pclk);
      chk("t1_wr1_width", {31'b0, wr_uart_1}, 0);
      @(negedge pclk);
      chk("t1_wr2_gap", {31'b0, wr_uart_2}, 0);
      @(negedge pclk);
      chk("t1_wr2_on", {31'b0, wr_uart_2}, 1);
      @(negedge pclk);
      chk("t1_wr2_width", {31'b0, wr_uart_2}, 0);
      npulse++;
      repeat (3) @(negedge pclk);

      // Link 1 full across two snapshots: only link 2 written, one drop.
      tx_full_1 = 1'b1;
      c1 = n_wr1; c2 = n_wr2;
      to_snap();
      snap_pulse(32'h0012_3405, 1'b1, 1'b0);
      chk("t3_drop_s2", {24'b0, tx_drop_cnt}, 0);
      to_snap();
      snap_pulse(32'h0012_3405, 1'b1, 1'b0);
      repeat (4) @(negedge pclk);
      chk("t3_drop_s3", {24'b0, tx_drop_cnt}, 1);
      chk("t3_no_wr1", n_wr1 - c1, 0);
      chk("t3_wr2_cnt", n_wr2 - c2, 2);
      tx_full_1 = 1'b0;
      repeat (8) @(negedge pclk);
      chk("t3_late_wr1", n_wr1 - c1, 1);

      // Link 1 served last, so link 2 goes first on the next snapshot.
      c1 = n_wr1; c2 = n_wr2;
      to_snap();
      snap_pulse(32'h00AB_CD05, 1'b0, 1'b0);
      repeat (6) @(negedge pclk);
      chk("t2_wr1_cnt", n_wr1 - c1, 1);
      chk("t2_wr2_cnt", n_wr2 - c2, 1);
      chk("t2_order", {31'b0, (t_wr2 < t_wr1)}, 1);
      chk("t2_drop", {24'b0, tx_drop_cnt}, 1);

      // Snapshot arriving while WR1 is in flight is deferred until after the write.
      to_snap();
      snap_pulse(32'h00C0_DE05, 1'b1, 1'b0);
      repeat (4) @(negedge pclk);
      to_snap();
      c1 = n_wr1; c2 = n_wr2;
      tx_data_in = 32'h00FA_CE05;
      tx_full_1  = 1'b0;
      vsync      = 1'b1;
      @(negedge pclk);
      chk("t4_wr1_inflight", {31'b0, wr_uart_1}, 1);
      chk("t4_word_inflight", tx_word, 32'h00C0_DE05);
      @(negedge pclk);
      vsync = 1'b0;
      chk("t4_word_gap", tx_word, 32'h00C0_DE05);
      @(negedge pclk);
      chk("t4_word_new", tx_word, 32'h00FA_CE05);
      exp_word = 32'h00FA_CE05;
      npulse++;
      repeat (10) @(negedge pclk);
      chk("t4_wr1_cnt", n_wr1 - c1, 2);
      chk("t4_wr2_cnt", n_wr2 - c2, 1);
      chk("t4_drop", {24'b0, tx_drop_cnt}, 1);

      // RX: valid word, then a null ID and our own ID.
      r1 = n_rd1;
      q1.push_back(32'h0000_0007);
      repeat (6) @(negedge pclk);
      chk("t5_rd1_cnt", n_rd1 - r1, 1);
      chk("t5_ext1", ext_data_1, 32'h0000_0007);
      chk("t5_up1", {31'b0, link_up_1}, 1);
      q1.push_back(32'h0000_0000);
      q1.push_back(32'hABCD_0005);
      repeat (8) @(negedge pclk);
      chk("t6_rd1_cnt", n_rd1 - r1, 3);
      chk("t6_ext1_kept", ext_data_1, 32'h0000_0007);

      // Timeout after three ticks without a valid word.
      pulse(); pulse();
      chk("t7_up_before", {31'b0, link_up_1}, 1);
      pulse();
      chk("t7_up_timeout", {31'b0, link_up_1}, 0);
      chk("t7_ext_timeout", ext_data_1, 0);

      // Valid word coinciding with the third tick keeps the link alive.
      q1.push_back(32'h0000_0107);
      repeat (6) @(negedge pclk);
      pulse(); pulse();
      q1.push_back(32'h5566_7788);
      pulse();
      chk("t7_coinc_up", {31'b0, link_up_1}, 1);
      chk("t7_coinc_ext", ext_data_1, 32'h5566_7788);
      pulse(); pulse();
      chk("t7_coinc_hold", {31'b0, link_up_1}, 1);

      // Randomized RX on both links against a last-valid-word model.
      m_ext1 = 32'h5566_7788; m_up1 = 1'b1;
      m_ext2 = 32'h0;         m_up2 = 1'b0;
      r1 = n_rd1; r2 = n_rd2;
      for (int i = 0; i < 24; i++) begin
         w = $urandom;
         case ($urandom_range(0, 3))
            0: w[7:0] = 8'h00;
            1: w[7:0] = 8'h05;
            default: w[7:0] = 8'h10 + 8'($urandom_range(0, 200));
         endcase
         if (i % 2 == 0) begin
            q1.push_back(w);
            if (w[7:0] != 8'h00 && w[7:0] != 8'h05) begin m_ext1 = w; m_up1 = 1'b1; end
         end else begin
            q2.push_back(w);
            if (w[7:0] != 8'h00 && w[7:0] != 8'h05) begin m_ext2 = w; m_up2 = 1'b1; end
         end
         repeat ($urandom_range(0, 3)) @(negedge pclk);
      end
      done = 1'b0;
      for (int k = 0; k < 300 && !done; k++) begin
         @(negedge pclk);
         if (q1.size() == 0 && q2.size() == 0) done = 1'b1;
      end
      chk("rx_drain_done", {31'b0, done}, 1);
      repeat (4) @(negedge pclk);
      chk("rx_rd1_cnt", n_rd1 - r1, 12);
      chk("rx_rd2_cnt", n_rd2 - r2, 12);
      chk("rx_ext1", ext_data_1, m_ext1);
      chk("rx_ext2", ext_data_2, m_ext2);
      chk("rx_up1", {31'b0, link_up_1}, {31'b0, m_up1});
      chk("rx_up2", {31'b0, link_up_2}, {31'b0, m_up2});

      // Randomized TX periods: each link not full gets one write, each full link one drop.
      exp_drop = 1;
      pf1 = 1'b0; pf2 = 1'b0;
      for (int k = 0; k < 6; k++) begin
         d  = $urandom;
         f1 = 1'($urandom_range(0, 1));
         f2 = 1'($urandom_range(0, 1));
         to_snap();
         c1 = n_wr1; c2 = n_wr2;
         snap_pulse(d, f1, f2);
         exp_drop = exp_drop + int'(pf1) + int'(pf2);
         chk("rtx_word", tx_word, d);
         chk("rtx_drop", {24'b0, tx_drop_cnt}, exp_drop);
         repeat (3) pulse();
         chk("rtx_wr1_cnt", n_wr1 - c1, {31'b0, ~f1});
         chk("rtx_wr2_cnt", n_wr2 - c2, {31'b0, ~f2});
         pf1 = f1; pf2 = f2;
      end

      // Both links blocked until the drop counter saturates.
      to_snap();
      for (int k = 0; k < 130; k++) begin
         snap_pulse(tx_data_in, 1'b1, 1'b1);
         exp_drop = exp_drop + int'(pf1) + int'(pf2);
         if (exp_drop > 255) exp_drop = 255;
         pf1 = 1'b1; pf2 = 1'b1;
         repeat (3) pulse();
      end
      chk("sat_drop", {24'b0, tx_drop_cnt}, exp_drop);
      chk("sat_drop_255", {24'b0, tx_drop_cnt}, 255);

      // Reset in the middle of a write: everything clears and the frame is not retried.
      tx_full_1 = 1'b0; tx_full_2 = 1'b0;
      done = 1'b0;
      for (int k = 0; k < 20 && !done; k++) begin
         @(negedge pclk);
         if (wr_uart_1 || wr_uart_2) done = 1'b1;
      end
      chk("mid_wr_seen", {31'b0, done}, 1);
      #2 rst = 1'b1;
      #1;
      chk("mid_rst_wr", {30'b0, wr_uart_2, wr_uart_1}, 0);
      chk("mid_rst_word", tx_word, 0);
      chk("mid_rst_drop", {24'b0, tx_drop_cnt}, 0);
      chk("mid_rst_ext2", ext_data_2, 0);
      @(negedge pclk);
      rst = 1'b0;
      c1 = n_wr1; c2 = n_wr2;
      repeat (10) @(negedge pclk);
      chk("no_retry", (n_wr1 - c1) + (n_wr2 - c2), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
